// File: rtl/seqn_run_fsm.sv
// Moore FSM detecting RUN_LEN consecutive equal bits on w, stepped by en.
// Define SEQ_RUN_HIT_CNT_EN to add the saturating terminal-hit counter (hit_clr/hit_cnt).
module seqn_run_fsm #(
   parameter int unsigned RUN_LEN = 4,
   parameter int unsigned OVERLAP = 1,
   parameter int unsigned CNT_W   = 8,
   localparam int unsigned STATE_W = $clog2(2 * RUN_LEN + 1)
) (
   input  logic               Clock,
   input  logic               nReset,
   input  logic               en,
   input  logic               w,
`ifdef SEQ_RUN_HIT_CNT_EN
   input  logic               hit_clr,
   output logic [CNT_W-1:0]   hit_cnt,
`endif
   output logic               z,
   output logic               z_pol,
   output logic [STATE_W-1:0] curr_state,
   output logic [STATE_W-1:0] next_state
);

   localparam logic [STATE_W-1:0] CodeIdle  = '0;
   localparam logic [STATE_W-1:0] CodeZero1 = STATE_W'(1);
   localparam logic [STATE_W-1:0] CodeT0    = STATE_W'(RUN_LEN);
   localparam logic [STATE_W-1:0] CodeOne1  = STATE_W'(RUN_LEN + 1);
   localparam logic [STATE_W-1:0] CodeT1    = STATE_W'(2 * RUN_LEN);

   // The state register holds the raw code; the enum names its decoded region.
   typedef enum logic [1:0] {
      StIdle,
      StZeros,
      StOnes,
      StUnused
   } state_class_e;

   logic [STATE_W-1:0] state_q, state_d;
   state_class_e       state_class;
   logic               is_term;
   logic               pol;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= CodeIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_class = StUnused;
      if (state_q == CodeIdle) begin
         state_class = StIdle;
      end else if (state_q <= CodeT0) begin
         state_class = StZeros;
      end else if (state_q <= CodeT1) begin
         state_class = StOnes;
      end
   end

   assign is_term = (state_q == CodeT0) || (state_q == CodeT1);
   assign pol     = (state_class == StOnes);

   always_comb begin
      state_d = state_q;
      unique case (state_class)
         StUnused: begin
            // Recover from illegal codes even while stepping is disabled.
            state_d = CodeIdle;
         end
         StIdle: begin
            if (en) begin
               state_d = w ? CodeOne1 : CodeZero1;
            end
         end
         StZeros, StOnes: begin
            if (en) begin
               if (w != pol) begin
                  state_d = w ? CodeOne1 : CodeZero1;
               end else if (!is_term) begin
                  state_d = state_q + STATE_W'(1);
               end else if (OVERLAP == 0) begin
                  state_d = pol ? CodeOne1 : CodeZero1;
               end
            end
         end
         default: begin
            state_d = CodeIdle;
         end
      endcase
   end

   assign curr_state = state_q;
   assign next_state = state_d;
   assign z          = is_term;
   assign z_pol      = (state_q == CodeT1);

`ifdef SEQ_RUN_HIT_CNT_EN
   localparam logic [CNT_W-1:0] HitMax = '1;

   logic             hit;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

   // A hit is any enabled edge that loads a terminal state, including a held one.
   assign hit = en && ((state_d == CodeT0) || (state_d == CodeT1));

   always_comb begin
      hit_cnt_d = hit_cnt_q;
      if (hit_clr) begin
         hit_cnt_d = '0;
      end else if (hit && (hit_cnt_q != HitMax)) begin
         hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         hit_cnt_q <= '0;
      end else begin
         hit_cnt_q <= hit_cnt_d;
      end
   end

   assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_seqn_run_fsm.sv
// Scoreboard bench for seqn_run_fsm: one OVERLAP=1 and one OVERLAP=0 instance share stimulus.
// Build with SEQ_RUN_HIT_CNT_EN defined to also check the 2-bit hit counters.
module tb_seqn_run_fsm;

   localparam int R = 4;

   logic       Clock = 1'b0;
   logic       nReset;
   logic       en;
   logic       w;
   logic       hit_clr;
   logic       z1, zp1, z0, zp0;
   logic [3:0] cs1, ns1, cs0, ns0;
`ifdef SEQ_RUN_HIT_CNT_EN
   logic [1:0] hc1, hc0;
`endif

   always #5 Clock = ~Clock;

   seqn_run_fsm #(.RUN_LEN(R), .OVERLAP(1), .CNT_W(2)) dut1 (
      .Clock     (Clock),
      .nReset    (nReset),
      .en        (en),
      .w         (w),
`ifdef SEQ_RUN_HIT_CNT_EN
      .hit_clr   (hit_clr),
      .hit_cnt   (hc1),
`endif
      .z         (z1),
      .z_pol     (zp1),
      .curr_state(cs1),
      .next_state(ns1)
   );

   seqn_run_fsm #(.RUN_LEN(R), .OVERLAP(0), .CNT_W(2)) dut0 (
      .Clock     (Clock),
      .nReset    (nReset),
      .en        (en),
      .w         (w),
`ifdef SEQ_RUN_HIT_CNT_EN
      .hit_clr   (hit_clr),
      .hit_cnt   (hc0),
`endif
      .z         (z0),
      .z_pol     (zp0),
      .curr_state(cs0),
      .next_state(ns0)
   );

   typedef struct {
      int s1;
      int s0;
      int h1;
      int h0;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_bad   = 0;

   // Reference model: (count, polarity) per instance; index 1 = OVERLAP=1.
   int   m_cnt[2];
   bit   m_pol[2];
   int   m_hit[2];

   int   tbl1_s1[5]  = '{5, 6, 7, 8, 8};
   int   tbl1_s0[5]  = '{5, 6, 7, 8, 5};
   int   tbl2_s[6]   = '{1, 5, 1, 5, 1, 5};
   int   tbl3_s0[8]  = '{1, 2, 3, 4, 1, 2, 3, 4};
   int   tbl6_s1[10] = '{5, 6, 7, 8, 8, 8, 8, 8, 8, 8};
   int   tbl6_h1[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 3};

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int code_of(input int c, input bit p);
      if (c == 0) return 0;
      return p ? R + c : c;
   endfunction

   task automatic model_step(input bit e, input bit wv, input bit clr);
      for (int i = 0; i < 2; i++) begin
         if (e) begin
            if (m_cnt[i] == 0 || wv != m_pol[i]) begin
               m_cnt[i] = 1;
               m_pol[i] = wv;
            end else if (m_cnt[i] < R) begin
               m_cnt[i]++;
            end else if (i == 0) begin
               m_cnt[i] = 1;
            end
         end
         if (clr) m_hit[i] = 0;
         else if (e && m_cnt[i] == R && m_hit[i] < 3) m_hit[i]++;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0;
         m_pol[i] = 1'b0;
         m_hit[i] = 0;
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_cs1"}, 32'(cs1), 0);
      check_eq({tag, "_cs0"}, 32'(cs0), 0);
      check_eq({tag, "_z1"}, 32'(z1), 0);
      check_eq({tag, "_zp1"}, 32'(zp1), 0);
      check_eq({tag, "_z0"}, 32'(z0), 0);
`ifdef SEQ_RUN_HIT_CNT_EN
      check_eq({tag, "_hc1"}, 32'(hc1), 0);
      check_eq({tag, "_hc0"}, 32'(hc0), 0);
`endif
   endtask

   // Table entries override the model when >= 0; the model always advances.
   task automatic step(input bit e, input bit wv, input bit clr,
                       input int t1, input int t0, input int th1);
      exp_t x;
      @(negedge Clock);
      en      = e;
      w       = wv;
      hit_clr = clr;
      model_step(e, wv, clr);
      x.s1 = (t1 >= 0) ? t1 : code_of(m_cnt[1], m_pol[1]);
      x.s0 = (t0 >= 0) ? t0 : code_of(m_cnt[0], m_pol[0]);
      x.h1 = (th1 >= 0) ? th1 : m_hit[1];
      x.h0 = m_hit[0];
      sb.push_back(x);
      #1;
      check_eq("next1", 32'(ns1), x.s1);
      check_eq("next0", 32'(ns0), x.s0);
      @(posedge Clock);
      #1;
      x = sb.pop_front();
      check_eq("curr1", 32'(cs1), x.s1);
      check_eq("curr0", 32'(cs0), x.s0);
      check_eq("z1", 32'(z1), 32'(x.s1 == R || x.s1 == 2 * R));
      check_eq("zpol1", 32'(zp1), 32'(x.s1 == 2 * R));
      check_eq("z0", 32'(z0), 32'(x.s0 == R || x.s0 == 2 * R));
      check_eq("zpol0", 32'(zp0), 32'(x.s0 == 2 * R));
`ifdef SEQ_RUN_HIT_CNT_EN
      check_eq("hit1", 32'(hc1), x.h1);
      check_eq("hit0", 32'(hc0), x.h0);
`endif
   endtask

   // Asserts reset between edges, checks the immediate clear, holds it over one edge.
   task automatic apply_reset(input string tag);
      @(negedge Clock);
      en      = 1'b0;
      hit_clr = 1'b0;
      #2 nReset = 1'b0;
      #1 check_reset_state({tag, "_async"});
      model_reset();
      @(posedge Clock);
      #1 check_reset_state({tag, "_held"});
      #1 nReset = 1'b1;
   endtask

   initial begin
      bit last_w;
      nReset  = 1'b1;
      en      = 1'b0;
      w       = 1'b0;
      hit_clr = 1'b0;
      model_reset();
      #1 nReset = 1'b0;
      #1 check_reset_state("por");
      @(negedge Clock);
      #1 nReset = 1'b1;

      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, tbl1_s1[i], tbl1_s0[i], -1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'(i % 2), 1'b0, tbl2_s[i], tbl2_s[i], -1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, -1, tbl3_s0[i], -1);

      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 5 + i, 5 + i, -1);
      apply_reset("midrun");
      step(1'b1, 1'b1, 1'b0, 5, 5, -1);

      step(1'b1, 1'b1, 1'b0, 6, 6, -1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'(i % 2), 1'b0, 6, 6, -1);
      step(1'b1, 1'b1, 1'b0, 7, 7, -1);

      apply_reset("hits");
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, tbl6_s1[i], -1, tbl6_h1[i]);
      step(1'b1, 1'b1, 1'b1, 8, -1, 0);
      step(1'b1, 1'b1, 1'b0, 8, -1, 1);

      last_w = 1'b0;
      for (int i = 0; i < 300; i++) begin
         bit e, wv, clr;
         if (i % 97 == 50) apply_reset("rand");
         e      = ($urandom_range(0, 3) != 0);
         wv     = ($urandom_range(0, 9) < 7) ? last_w : ~last_w;
         clr    = ($urandom_range(0, 15) == 0);
         last_w = wv;
         step(e, wv, clr, -1, -1, -1);
      end

      check_eq("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got still running want finished by %0t", $time);
      $fatal(1, "simulation time limit reached");
   end

endmodule
